// File: rtl/fibonacci_gen_if.sv
// fibonacci_gen_if: control and term outputs of the Fibonacci generator
interface fibonacci_gen_if #(parameter int WIDTH = 32, parameter int IDX_W = 8);
  logic en;
  logic clear;
  logic [WIDTH-1:0] value;
  logic [IDX_W-1:0] idx;
  logic ovf;
  modport master (output en, clear, input value, idx, ovf);
  modport slave (input en, clear, output value, idx, ovf);
endinterface

// File: rtl/fibonacci_gen.sv
// fibonacci_gen: free-running Fibonacci term generator, wraps by default
// FIBONACCI_SATURATE_EN freezes at the last representable term
module fibonacci_gen #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 8
) (
  input logic clk,
  input logic rst,
  fibonacci_gen_if.slave bus
);
  logic [WIDTH-1:0] a, b, b_next;
  logic [IDX_W-1:0] idx;
  logic ovf, adv;
  logic [WIDTH:0] sum;
  assign sum = {1'b0, a} + {1'b0, b};
`ifdef FIBONACCI_SATURATE_EN
  // once a carry is seen the sequence is frozen until clear/reset
  assign adv = bus.en & ~ovf;
  assign b_next = sum[WIDTH] ? b : sum[WIDTH-1:0];
`else
  assign adv = bus.en;
  assign b_next = sum[WIDTH-1:0];
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst || bus.clear) begin
      a <= '0;
      b <= WIDTH'(1);
      idx <= '0;
      ovf <= 1'b0;
    end else if (adv) begin
      a <= b;
      b <= b_next;
      idx <= idx + 1'b1;
      ovf <= ovf | sum[WIDTH];
    end
  end
  assign bus.value = a;
  assign bus.idx = idx;
  assign bus.ovf = ovf;
endmodule

// File: tb/tb_fibonacci_gen.sv
// tb_fibonacci_gen: directed checks on a 32-bit and an 8-bit generator
module tb_fibonacci_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic clear = 1'b0;
  int total = 0;
  int bad = 0;
  fibonacci_gen_if #(.WIDTH(32), .IDX_W(8)) f32 ();
  fibonacci_gen_if #(.WIDTH(8), .IDX_W(8)) f8 ();
  assign f32.en = en;
  assign f32.clear = clear;
  assign f8.en = en;
  assign f8.clear = clear;
  fibonacci_gen #(.WIDTH(32), .IDX_W(8)) dut32 (.clk(clk), .rst(rst), .bus(f32));
  fibonacci_gen #(.WIDTH(8), .IDX_W(8)) dut8 (.clk(clk), .rst(rst), .bus(f8));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  int seq15[15] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};

  initial begin
    #1;
    check("rst_value", 64'(f32.value), 0);
    check("rst_idx", 64'(f32.idx), 0);
    check("rst_ovf", 64'(f32.ovf), 0);
    tick(1);
    rst = 1'b1;
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      check($sformatf("seq%0d", i + 1), 64'(f32.value), 64'(seq15[i]));
    end
    check("seq_idx", 64'(f32.idx), 15);
    en = 1'b0;
    do_clear();
    check("clr_value", 64'(f32.value), 0);
    check("clr_idx", 64'(f32.idx), 0);
    en = 1'b1;
    tick(4);
    check("gate_value4", 64'(f32.value), 3);
    en = 1'b0;
    tick(5);
    check("gate_hold_value", 64'(f32.value), 3);
    check("gate_hold_idx", 64'(f32.idx), 4);
    en = 1'b1;
    tick(1);
    check("gate_resume", 64'(f32.value), 5);
    do_clear();
    tick(10);
    check("run10", 64'(f32.value), 55);
    do_clear();
    check("clr_pri_value", 64'(f32.value), 0);
    check("clr_pri_idx", 64'(f32.idx), 0);
    tick(1);
    check("clr_next", 64'(f32.value), 1);
    do_clear();
    tick(8);
    check("pre_async", 64'(f32.value), 21);
    #2;
    rst = 1'b0;
    #1;
    check("async_value", 64'(f32.value), 0);
    check("async_idx", 64'(f32.idx), 0);
    tick(1);
    rst = 1'b1;
    tick(1);
    check("restart1", 64'(f32.value), 1);
    tick(1);
    check("restart2", 64'(f32.value), 1);
    tick(1);
    check("restart3", 64'(f32.value), 2);
    do_clear();
    tick(12);
    check("w8_pre_value", 64'(f8.value), 144);
    check("w8_pre_ovf", 64'(f8.ovf), 0);
    tick(1);
    check("w8_value13", 64'(f8.value), 233);
    check("w8_idx13", 64'(f8.idx), 13);
    check("w8_ovf13", 64'(f8.ovf), 1);
`ifdef FIBONACCI_SATURATE_EN
    tick(7);
    check("sat_value", 64'(f8.value), 233);
    check("sat_idx", 64'(f8.idx), 13);
    check("sat_ovf", 64'(f8.ovf), 1);
`else
    tick(1);
    check("wrap_value14", 64'(f8.value), 121);
    check("wrap_ovf14", 64'(f8.ovf), 1);
    tick(1);
    check("wrap_value15", 64'(f8.value), 98);
    check("wrap_ovf15", 64'(f8.ovf), 1);
`endif
    en = 1'b0;
    do_clear();
    check("w8_clr_value", 64'(f8.value), 0);
    check("w8_clr_ovf", 64'(f8.ovf), 0);
    en = 1'b1;
    tick(46);
    check("f46_value", 64'(f32.value), 64'd1836311903);
    check("f46_ovf", 64'(f32.ovf), 0);
    tick(1);
    check("f47_value", 64'(f32.value), 64'd2971215073);
    check("f47_ovf", 64'(f32.ovf), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
